image_frame_reader: RTL and testbench

//  Drains a filtered WIDTHxHEIGHT 8-bit image out of the frame RAM.
//  The median filter writes this RAM; this block is its reader.

---
 rtl/image_frame_reader_pkg.sv | 26 ++
 rtl/image_frame_reader_scan_counter.sv | 37 +++
 rtl/image_frame_reader.sv | 114 +++++++++++
 tb/tb_image_frame_reader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/image_frame_reader_pkg.sv
// Shared geometry, types and FSM encoding for the frame reader.
// Package name: image_pkg.
package image_pkg;

  localparam int unsigned IMG_W  = 100;
  localparam int unsigned IMG_H  = 100;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned N      = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned CHK_W  = 16;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} rd_state_t;

  // One outgoing stream beat: pixel plus its raster tags.
  typedef struct packed {
    pixel_t             data;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               last;
  } px_beat_t;

endpackage

// File: rtl/image_frame_reader_scan_counter.sv
// Raster scan counter: idx (== RAM address), row and col kept in lockstep.
// Ports: clk, rst (sync, active-high), clear (back to pixel 0), step
// (advance one pixel, saturates at the last one), addr/row/col (registered),
// last_c (combinational: current pixel is N-1).
module image_scan_counter
  import image_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last_c
);

  assign last_c = (addr == ADDR_W'(N - 1));

  // Incremental address with column wrap; no multiplier needed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr <= '0;
      row  <= '0;
      col  <= '0;
    end else if (step && !last_c) begin
      addr <= addr + ADDR_W'(1);
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/image_frame_reader.sv
// Frame RAM reader: walks the frame in raster order and streams each pixel
// on a valid/ready interface with row/col/last tags.
// Ports: clk, rst (sync, active-high), start, busy, done, rd_en, rd_addr,
// rd_data, px_data, px_valid, px_ready, px_row, px_col, px_last, and
// checksum when IMAGE_FRAME_READER_CHECKSUM_EN is defined.
// Optional feature macro: IMAGE_FRAME_READER_CHECKSUM_EN (16-bit wrapping
// sum of accepted pixels).
module image_frame_reader
  import image_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ROW_W-1:0]  px_row,
  output logic [COL_W-1:0]  px_col,
  output logic              px_last
`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
  ,
  output logic [CHK_W-1:0]  checksum
`endif
);

  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  rd_state_t         state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last_c;
  logic              accept_c;
  logic              start_ok_c;
  logic              idx_last_c;
  logic [ROW_W-1:0]  cnt_row;
  logic [COL_W-1:0]  cnt_col;
  px_beat_t          beat_q;

  assign wait_last_c = (wait_cnt == WAIT_W'(RD_LAT - 1));
  assign accept_c    = (state == SEND) && px_ready;
  assign start_ok_c  = (state == IDLE) && start;

  image_scan_counter u_scan (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok_c),
    .step   (accept_c),
    .addr   (rd_addr),
    .row    (cnt_row),
    .col    (cnt_col),
    .last_c (idx_last_c)
  );

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = WAIT;
      WAIT:    if (wait_last_c) state_next = SEND;
      SEND:    if (px_ready) state_next = idx_last_c ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      px_valid <= 1'b0;
      beat_q   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT && !wait_last_c) ? wait_cnt + WAIT_W'(1) : '0;
      busy     <= (state_next == FETCH) || (state_next == WAIT) || (state_next == SEND);
      done     <= (state_next == DONE);
      rd_en    <= (state_next == FETCH);
      px_valid <= (state_next == SEND);
      // Capture on the final WAIT cycle; held untouched through SEND.
      if (state == WAIT && wait_last_c) begin
        beat_q <= '{data: rd_data, row: cnt_row, col: cnt_col, last: idx_last_c};
      end
    end
  end

  assign px_data = beat_q.data;
  assign px_row  = beat_q.row;
  assign px_col  = beat_q.col;
  assign px_last = beat_q.last;

`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
  // Running sum of accepted pixels; stays put after done until next start.
  always_ff @(posedge clk) begin
    if (rst || start_ok_c) begin
      checksum <= '0;
    end else if (accept_c) begin
      checksum <= checksum + CHK_W'(beat_q.data);
    end
  end
`endif

endmodule

// File: tb/tb_image_frame_reader.sv
module tb_image_frame_reader;
  import image_pkg::*;

  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst, start, px_ready;
  logic              busy, done, rd_en, px_valid, px_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data, px_data;
  logic [ROW_W-1:0]  px_row;
  logic [COL_W-1:0]  px_col;
`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
  logic [CHK_W-1:0]  checksum;
`endif

  int errors = 0;
  int checks = 0;

  pixel_t mem [N];

  always #5 clk = ~clk;

  image_frame_reader #(.RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .px_data  (px_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_row   (px_row),
    .px_col   (px_col),
    .px_last  (px_last)
`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // Single-cycle-latency frame RAM model.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat for raster index k, straight from the coordinate rules.
  function automatic logic [63:0] exp_beat(input int k);
    logic [PIX_W-1:0] d;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    d = mem[k];
    r = ROW_W'(k / int'(IMG_W));
    c = COL_W'(k % int'(IMG_W));
    return 64'({d, r, c, (k == int'(N) - 1)});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  64'(busy),     64'(0));
    check({tag, "_done"},  64'(done),     64'(0));
    check({tag, "_rd_en"}, 64'(rd_en),    64'(0));
    check({tag, "_addr"},  64'(rd_addr),  64'(0));
    check({tag, "_valid"}, 64'(px_valid), 64'(0));
    check({tag, "_beat"},  64'({px_data, px_row, px_col, px_last}), 64'(0));
`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
    check({tag, "_csum"},  64'(checksum), 64'(0));
`endif
  endtask

  // Run one frame; optional random ready, stall window, in-flight start
  // pulse and mid-frame reset at given pixel indices (-1 = unused).
  task automatic run_frame(input bit rnd, input int stall_pix, input int start_pix,
                           input int abort_pix, input bit check_lat);
    int k, cyc, stall_left;
    bit stall_done, start_done;
    logic [15:0] sum;
    k = 0; stall_left = 0; stall_done = 0; start_done = 0; sum = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("fetch0_rd_en", 64'(rd_en), 64'(1));
    while (cyc < 60000) begin
      start = 1'b0;
      if (px_valid && k == stall_pix && !stall_done) begin
        stall_left = 5;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        px_ready = 1'b0;
        stall_left--;
      end else begin
        px_ready = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
      if (px_valid && k == start_pix && !start_done) begin
        start = 1'b1;
        start_done = 1;
      end
      if (px_valid && k == abort_pix) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        px_ready = 1'b0;
        check_idle("abort");
        return;
      end
      if (rd_en) check("rd_addr", 64'(rd_addr), 64'(k));
      if (px_valid) check("pixel", 64'({px_data, px_row, px_col, px_last}), exp_beat(k));
      if (done) begin
        check("done_count", 64'(k), 64'(N));
        if (check_lat) check("latency", 64'(cyc), 64'((RD_LAT + 2) * N + 1));
`ifdef IMAGE_FRAME_READER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(sum));
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_done_busy", 64'({busy, px_valid, done}), 64'(0));
        tick();
        check("start_at_done_ignored", 64'({busy, rd_en}), 64'(0));
        return;
      end
      if (px_valid && px_ready) begin
        sum = sum + 16'(mem[k]);
        k++;
      end
      tick();
      cyc++;
    end
    check("frame_timeout", 64'(k), 64'(N));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; px_ready = 1'b0;
    for (int a = 0; a < int'(N); a++) mem[a] = 8'(a);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    run_frame(1'b0, -1, -1, -1, 1'b1);
    run_frame(1'b1, 37, 200, -1, 1'b0);

    for (int a = 0; a < int'(N); a++) mem[a] = 8'($urandom);
    run_frame(1'b0, -1, -1, 500, 1'b0);
    tick();
    for (int a = 0; a < int'(N); a++) mem[a] = 8'($urandom);
    run_frame(1'b1, -1, -1, 50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
